// File: rtl/exu_lsu_ctrl_if.sv
// AGU command/response, DTCM SRAM and write-back channels of the EXU load/store controller.
interface exu_lsu_ctrl_if #(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int ITAG_WIDTH      = 1
);
  logic                         agu_cmd_valid;
  logic                         agu_cmd_ready;
  logic [DTCM_ADDR_WIDTH-1:0]   agu_cmd_addr;
  logic                         agu_cmd_read;
  logic [XLEN-1:0]              agu_cmd_wdata;
  logic [XLEN/8-1:0]            agu_cmd_wmask;
  logic [ITAG_WIDTH-1:0]        agu_cmd_itag;
  logic                         agu_cmd_usign;
  logic [1:0]                   agu_cmd_size;
  logic                         agu_rsp_valid;
  logic                         agu_rsp_ready;

  logic                         dtcm_cs;
  logic                         dtcm_we;
  logic [DTCM_ADDR_WIDTH-3:0]   dtcm_addr;
  logic [XLEN/8-1:0]            dtcm_wem;
  logic [XLEN-1:0]              dtcm_din;
  logic [XLEN-1:0]              dtcm_dout;

  logic                         lsu_o_valid;
  logic                         lsu_o_ready;
  logic                         lsu_o_wbck_en;
  logic [XLEN-1:0]              lsu_o_wbck_wdat;
  logic [ITAG_WIDTH-1:0]        lsu_o_itag;
  logic                         lsu_o_err;

  modport slave (
    input  agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_wdata, agu_cmd_wmask,
           agu_cmd_itag, agu_cmd_usign, agu_cmd_size, agu_rsp_ready, dtcm_dout, lsu_o_ready,
    output agu_cmd_ready, agu_rsp_valid, dtcm_cs, dtcm_we, dtcm_addr, dtcm_wem, dtcm_din,
           lsu_o_valid, lsu_o_wbck_en, lsu_o_wbck_wdat, lsu_o_itag, lsu_o_err
  );

  modport master (
    output agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_wdata, agu_cmd_wmask,
           agu_cmd_itag, agu_cmd_usign, agu_cmd_size, agu_rsp_ready, dtcm_dout, lsu_o_ready,
    input  agu_cmd_ready, agu_rsp_valid, dtcm_cs, dtcm_we, dtcm_addr, dtcm_wem, dtcm_din,
           lsu_o_valid, lsu_o_wbck_en, lsu_o_wbck_wdat, lsu_o_itag, lsu_o_err
  );
endinterface

// File: rtl/exu_lsu_ctrl.sv
// DTCM load/store controller: accepts AGU commands, drives the SRAM, formats load data and
// returns in-order write-back responses through a one-entry pending stage and a response FIFO.
module exu_lsu_ctrl #(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int ITAG_WIDTH      = 1,
  parameter int OUTS_DEPTH      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  exu_lsu_ctrl_if.slave   bus
);
  // Pending can always push: FIFO holds every in-flight credit so no push ever stalls.
  localparam int FIFO_DEPTH = OUTS_DEPTH;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  logic                   accept, misaligned, push, pop;
  logic                   pend_valid, pend_read, pend_usign, pend_err;
  logic [1:0]             pend_size, pend_off;
  logic [ITAG_WIDTH-1:0]  pend_itag;
  logic [XLEN-1:0]        fmt_wdat;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;

  logic [XLEN-1:0]        fifo_wdat [FIFO_DEPTH];
  logic [ITAG_WIDTH-1:0]  fifo_itag [FIFO_DEPTH];
  logic                   fifo_wbck [FIFO_DEPTH];
  logic                   fifo_err  [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          fifo_cnt, occ;
  logic                   unused_rsp_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign unused_rsp_ready   = bus.agu_rsp_ready;
  assign occ                = fifo_cnt + CW'(pend_valid);
  assign bus.agu_cmd_ready  = (occ < CW'(OUTS_DEPTH));
  assign accept             = bus.agu_cmd_valid & bus.agu_cmd_ready;
  assign misaligned         = ((bus.agu_cmd_size == 2'b01) & bus.agu_cmd_addr[0])
                            | (bus.agu_cmd_size[1] & (bus.agu_cmd_addr[1:0] != 2'b00));
  assign push               = pend_valid;
  assign pop                = (fifo_cnt != '0) & bus.lsu_o_ready;

  always_comb begin
    bus.dtcm_cs   = 1'b0;
    bus.dtcm_we   = 1'b0;
    bus.dtcm_addr = '0;
    bus.dtcm_wem  = '0;
    bus.dtcm_din  = '0;
    if (accept) begin
      bus.dtcm_cs   = ~misaligned;
      bus.dtcm_we   = ~bus.agu_cmd_read;
      bus.dtcm_addr = bus.agu_cmd_addr[DTCM_ADDR_WIDTH-1:2];
      bus.dtcm_wem  = bus.agu_cmd_read ? '0 : bus.agu_cmd_wmask;
      bus.dtcm_din  = bus.agu_cmd_wdata;
    end
  end

  always_comb begin
    ld_byte  = bus.dtcm_dout[{pend_off, 3'b000} +: 8];
    ld_half  = bus.dtcm_dout[{pend_off[1], 4'b0000} +: 16];
    fmt_wdat = '0;
    if (pend_read && !pend_err) begin
      case (pend_size)
        2'b00:   fmt_wdat = {{(XLEN-8){ld_byte[7] & ~pend_usign}}, ld_byte};
        2'b01:   fmt_wdat = {{(XLEN-16){ld_half[15] & ~pend_usign}}, ld_half};
        default: fmt_wdat = bus.dtcm_dout;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_read  <= 1'b0;
      pend_usign <= 1'b0;
      pend_err   <= 1'b0;
      pend_size  <= '0;
      pend_off   <= '0;
      pend_itag  <= '0;
    end else begin
      pend_valid <= accept;
      if (accept) begin
        pend_read  <= bus.agu_cmd_read;
        pend_usign <= bus.agu_cmd_usign;
        pend_err   <= misaligned;
        pend_size  <= bus.agu_cmd_size;
        pend_off   <= bus.agu_cmd_addr[1:0];
        pend_itag  <= bus.agu_cmd_itag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wdat[wr_ptr] <= fmt_wdat;
      fifo_itag[wr_ptr] <= pend_itag;
      fifo_wbck[wr_ptr] <= pend_read & ~pend_err;
      fifo_err[wr_ptr]  <= pend_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) assert (fifo_cnt != CW'(FIFO_DEPTH));
  end

  assign bus.lsu_o_valid     = (fifo_cnt != '0);
  assign bus.lsu_o_wbck_en   = fifo_wbck[rd_ptr];
  assign bus.lsu_o_wbck_wdat = fifo_wdat[rd_ptr];
  assign bus.lsu_o_itag      = fifo_itag[rd_ptr];
  assign bus.lsu_o_err       = fifo_err[rd_ptr];
  assign bus.agu_rsp_valid   = pop;
endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// Bench for exu_lsu_ctrl: DTCM SRAM model plus a byte-level memory / response-queue reference.
module tb_exu_lsu_ctrl;
  localparam int XLEN = 32;
  localparam int AW   = 16;
  localparam int IW   = 1;
  localparam int OD   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exu_lsu_ctrl_if #(.XLEN(XLEN), .DTCM_ADDR_WIDTH(AW), .ITAG_WIDTH(IW)) bus();
  exu_lsu_ctrl #(.XLEN(XLEN), .DTCM_ADDR_WIDTH(AW), .ITAG_WIDTH(IW), .OUTS_DEPTH(OD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  // SRAM model: one-cycle read latency, byte write enables.
  logic [31:0] init_words [64];
  logic [31:0] sram [64];
  logic [31:0] dout_r = '0;
  logic        loading = 1'b1;
  logic        unused_hi;
  assign bus.dtcm_dout = dout_r;
  assign unused_hi = ^bus.dtcm_addr[AW-3:6];

  always @(posedge clk) begin
    if (loading) begin
      for (int i = 0; i < 64; i++) sram[i] <= init_words[i];
    end else if (bus.dtcm_cs) begin
      if (bus.dtcm_we) begin
        for (int k = 0; k < 4; k++)
          if (bus.dtcm_wem[k]) sram[bus.dtcm_addr[5:0]][8*k +: 8] <= bus.dtcm_din[8*k +: 8];
      end else begin
        dout_r <= sram[bus.dtcm_addr[5:0]];
      end
    end
  end

  typedef struct {
    logic        wbck;
    logic [31:0] wdat;
    logic        itag;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [256];
  int          tests = 0, fails = 0, cyc = 0;
  int          rsp_count = 0, acc_count = 0, pulses = 0, last_pop_cyc = 0;
  bit          strict = 1'b0;
  logic [31:0] last_wdat = '0;
  logic        last_wbck = 1'b0, last_err = 1'b0, last_itag = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value a load returns, from byte memory and plain arithmetic.
  function automatic logic [31:0] ref_load(input int a, input int n, input logic us);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
    if (!us && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic monitor(output bit acc);
    int   a, n;
    bit   mis, pop;
    exp_t e;
    acc = 1'b0;
    if (!rst_n) return;
    chk("cmd_ready", 32'(bus.agu_cmd_ready), 32'(exp_q.size() < OD));
    acc = bus.agu_cmd_valid && bus.agu_cmd_ready;
    a   = int'(bus.agu_cmd_addr);
    n   = (bus.agu_cmd_size == 2'd0) ? 1 : (bus.agu_cmd_size == 2'd1) ? 2 : 4;
    mis = (a % n) != 0;
    chk("dtcm_cs", 32'(bus.dtcm_cs), 32'(acc && !mis));
    pop = bus.lsu_o_valid && bus.lsu_o_ready;
    chk("agu_rsp_valid", 32'(bus.agu_rsp_valid), 32'(pop));
    if (bus.agu_rsp_valid) pulses++;
    if (bus.lsu_o_valid) begin
      if (exp_q.size() == 0) begin
        chk("stale_rsp", 32'(bus.lsu_o_valid), 32'd0);
      end else begin
        e = exp_q[0];
        chk("wbck_en", 32'(bus.lsu_o_wbck_en), 32'(e.wbck));
        chk("wbck_wdat", bus.lsu_o_wbck_wdat, e.wdat);
        chk("itag", 32'(bus.lsu_o_itag), 32'(e.itag));
        chk("err", 32'(bus.lsu_o_err), 32'(e.err));
        if (pop) begin
          if (strict) chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
          void'(exp_q.pop_front());
          rsp_count++;
          last_pop_cyc = cyc;
          last_wdat = bus.lsu_o_wbck_wdat;
          last_wbck = bus.lsu_o_wbck_en;
          last_err  = bus.lsu_o_err;
          last_itag = bus.lsu_o_itag;
        end
      end
    end
    if (acc) begin
      e.itag = bus.agu_cmd_itag;
      e.err = mis;
      e.acc_cyc = cyc;
      e.wdat = '0;
      e.wbck = 1'b0;
      if (bus.agu_cmd_read) begin
        e.wbck = !mis;
        if (!mis) e.wdat = ref_load(a, n, bus.agu_cmd_usign);
      end else if (!mis) begin
        for (int k = 0; k < 4; k++)
          if (bus.agu_cmd_wmask[k]) ref_mem[(a & ~3) + k] = bus.agu_cmd_wdata[8*k +: 8];
      end
      exp_q.push_back(e);
      acc_count++;
    end
  endtask

  task automatic step(output bit acc);
    @(negedge clk);
    monitor(acc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic rd, input int addr, input logic [1:0] sz, input logic us,
                       input logic [31:0] wd, input logic [3:0] wm, input logic tag);
    bus.agu_cmd_valid = 1'b1;
    bus.agu_cmd_read  = rd;
    bus.agu_cmd_addr  = AW'(addr);
    bus.agu_cmd_size  = sz;
    bus.agu_cmd_usign = us;
    bus.agu_cmd_wdata = wd;
    bus.agu_cmd_wmask = wm;
    bus.agu_cmd_itag  = tag;
  endtask

  task automatic send(input logic rd, input int addr, input logic [1:0] sz, input logic us,
                      input logic [31:0] wd, input logic [3:0] wm, input logic tag);
    bit acc = 1'b0;
    drive(rd, addr, sz, us, wd, wm, tag);
    for (int i = 0; i < 50; i++) begin
      step(acc);
      if (acc) break;
      bus.lsu_o_ready = 1'b1;
    end
    chk("accepted", 32'(acc), 32'd1);
    bus.agu_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    bit a;
    for (int i = 0; i < 100; i++) begin
      if (rsp_count >= target) break;
      step(a);
    end
    chk("rsp_count", 32'(rsp_count), 32'(target));
  endtask

  task automatic do_cmd(input logic rd, input int addr, input logic [1:0] sz, input logic us,
                        input logic [31:0] wd, input logic [3:0] wm, input logic tag);
    int t = rsp_count + 1;
    send(rd, addr, sz, us, wd, wm, tag);
    wait_rsp(t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit a;
    int base, base_r, c0;
    bus.agu_cmd_valid = 1'b0;
    bus.agu_rsp_ready = 1'b1;
    bus.lsu_o_ready   = 1'b1;
    drive(1'b1, 0, 2'b10, 1'b0, '0, '0, 1'b0);
    bus.agu_cmd_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = (i == 0) ? 32'h8765_F0A1 : $urandom;
      init_words[i] = w;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = 8'((w >> (8 * k)) & 32'hFF);
    end
    repeat (3) @(posedge clk);
    #1;
    loading = 1'b0;
    rst_n   = 1'b1;
    chk("rst_cmd_ready", 32'(bus.agu_cmd_ready), 32'd1);
    chk("rst_lsu_valid", 32'(bus.lsu_o_valid), 32'd0);
    chk("rst_rsp_valid", 32'(bus.agu_rsp_valid), 32'd0);
    chk("rst_dtcm_cs", 32'(bus.dtcm_cs), 32'd0);

    // Directed loads on word 0 = 0x8765_F0A1.
    strict = 1'b1;
    do_cmd(1'b1, 1, 2'b00, 1'b0, '0, '0, 1'b0);
    chk("lb", last_wdat, 32'hFFFF_FFF0);
    chk("lb_wbck", 32'(last_wbck), 32'd1);
    do_cmd(1'b1, 1, 2'b00, 1'b1, '0, '0, 1'b1);
    chk("lbu", last_wdat, 32'h0000_00F0);
    chk("lbu_itag", 32'(last_itag), 32'd1);
    do_cmd(1'b1, 2, 2'b01, 1'b0, '0, '0, 1'b0);
    chk("lh", last_wdat, 32'hFFFF_8765);
    do_cmd(1'b1, 2, 2'b01, 1'b1, '0, '0, 1'b1);
    chk("lhu", last_wdat, 32'h0000_8765);
    do_cmd(1'b1, 0, 2'b10, 1'b0, '0, '0, 1'b0);
    chk("lw", last_wdat, 32'h8765_F0A1);

    // Store then byte store, read back.
    do_cmd(1'b0, 0, 2'b10, 1'b0, 32'h1111_1111, 4'hF, 1'b1);
    chk("sw_wbck", 32'(last_wbck), 32'd0);
    chk("sw_wdat", last_wdat, 32'd0);
    do_cmd(1'b0, 3, 2'b00, 1'b0, 32'h5A5A_5A5A, 4'h8, 1'b0);
    do_cmd(1'b1, 0, 2'b10, 1'b0, '0, '0, 1'b1);
    chk("sb_readback", last_wdat, 32'h5A11_1111);

    // Misaligned accesses.
    do_cmd(1'b1, 1, 2'b01, 1'b0, '0, '0, 1'b0);
    chk("mis_lh_err", 32'(last_err), 32'd1);
    chk("mis_lh_wdat", last_wdat, 32'd0);
    do_cmd(1'b0, 2, 2'b10, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b1);
    chk("mis_sw_err", 32'(last_err), 32'd1);
    do_cmd(1'b1, 0, 2'b10, 1'b0, '0, '0, 1'b0);
    chk("mis_neighbour0", last_wdat, 32'h5A11_1111);
    do_cmd(1'b1, 4, 2'b10, 1'b0, '0, '0, 1'b1);

    // Backpressure: three accepted, the fourth waits until responses drain.
    strict = 1'b0;
    bus.lsu_o_ready = 1'b0;
    base = acc_count;
    base_r = rsp_count;
    for (int i = 0; i < 3; i++) send(1'b1, 8 + 4 * i, 2'b10, 1'b0, '0, '0, 1'(i));
    drive(1'b1, 20, 2'b10, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(a);
    chk("bp_cmd_ready", 32'(bus.agu_cmd_ready), 32'd0);
    chk("bp_accepts", 32'(acc_count - base), 32'd3);
    chk("bp_lsu_valid", 32'(bus.lsu_o_valid), 32'd1);
    bus.lsu_o_ready = 1'b1;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) step(a);
    chk("bp_4th_accepted", 32'(a), 32'd1);
    bus.agu_cmd_valid = 1'b0;
    send(1'b1, 24, 2'b10, 1'b0, '0, '0, 1'b0);
    wait_rsp(base_r + 5);
    chk("bp_total", 32'(acc_count - base), 32'd5);

    // Full rate: 16 back-to-back loads.
    strict = 1'b1;
    c0 = cyc;
    base_r = rsp_count;
    base = pulses;
    for (int i = 0; i < 16; i++)
      send(1'b1, (4 * i) + (i % 4), 2'(i % 3), 1'(i / 8), '0, '0, 1'(i));
    chk("fr_cycles", 32'(cyc - c0), 32'd16);
    wait_rsp(base_r + 16);
    chk("fr_last_pop", 32'(last_pop_cyc), 32'(c0 + 17));
    chk("fr_pulses", 32'(pulses - base), 32'd16);

    // Randomized mix with random backpressure and idle gaps.
    strict = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus.lsu_o_ready = ($urandom_range(0, 3) != 0);
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) step(a);
    end
    bus.lsu_o_ready = 1'b1;
    wait_rsp(acc_count);

    // Reset with two loads in flight: no response may survive.
    strict = 1'b1;
    send(1'b1, 0, 2'b10, 1'b0, '0, '0, 1'b0);
    send(1'b1, 4, 2'b10, 1'b0, '0, '0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_lsu_valid", 32'(bus.lsu_o_valid), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.agu_rsp_valid), 32'd0);
    exp_q.delete();
    acc_count = rsp_count;
    step(a);
    step(a);
    rst_n = 1'b1;
    chk("post_rst_cmd_ready", 32'(bus.agu_cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) step(a);
    do_cmd(1'b1, 8, 2'b10, 1'b0, '0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
